// File: rtl/csr_counter.sv
// csr_counter -- machine counter and identification CSR group.
//
// Provides the read-only identification CSRs (mvendorid, marchid, mimpid,
// mhartid), the live 64-bit counters mcycle and minstret, optional
// hardware performance counters with event selectors, mcountinhibit,
// and the user-mode read-only counter shadows.
//
// Build option: define PRV664_HPM_EN to implement the mhpmcounterN /
// mhpmeventN pairs (N = 3 .. 3+HPM_NUM-1). Without it, those addresses
// still decode as hits but read zero and ignore writes.
//
// Ports:
//   clk_i        - clock
//   arst_i       - asynchronous active-low reset
//   raddr_i      - CSR read address
//   rdata_o      - read data (combinational, zero when not a hit)
//   hit_o        - raddr_i belongs to this group
//   we_i         - write strobe
//   waddr_i      - CSR write address
//   wdata_i      - write data
//   wr_illegal_o - write targets a read-only CSR of this group
//   instret_i    - instructions retired this cycle (0..2)
//   hpm_event_i  - event pulses, bit k-1 is event k
`ifndef XLEN
`define XLEN 64
`endif

module csr_counter #(
    parameter logic [63:0] HARTID  = 64'h0,
    parameter int          HPM_NUM = 4,
    parameter int          HPM_EVT = 8
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [11:0]        raddr_i,
    output logic [`XLEN-1:0]   rdata_o,
    output logic               hit_o,
    input  logic               we_i,
    input  logic [11:0]        waddr_i,
    input  logic [`XLEN-1:0]   wdata_i,
    output logic               wr_illegal_o,
    input  logic [1:0]         instret_i,
    input  logic [HPM_EVT-1:0] hpm_event_i
);

    localparam logic [63:0] MVENDORID = {8'h00, "KOROLEV"};
    localparam logic [63:0] MARCHID   = {8'h00, "VOSKHOD"};

    // Address pages (addr[11:5]): 0xB00, 0xC00 and 0x320 blocks of 32.
    localparam logic [6:0] PAGE_MCNT = 7'h58;
    localparam logic [6:0] PAGE_UCNT = 7'h60;
    localparam logic [6:0] PAGE_MEVT = 7'h19;

`ifdef PRV664_HPM_EN
    localparam logic [31:0] HPM_MASK = 32'(((64'd1 << HPM_NUM) - 64'd1) << 3);
`else
    localparam logic [31:0] HPM_MASK = 32'h0;
`endif
    // Bit 1 (time) is never implemented here.
    localparam logic [31:0] INH_MASK = HPM_MASK | 32'h0000_0005;

    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [31:0] inhibit;

    logic [6:0] rpage;
    logic [6:0] wpage;
    logic [4:0] ridx;
    logic [4:0] widx;

    assign rpage = raddr_i[11:5];
    assign ridx  = raddr_i[4:0];
    assign wpage = waddr_i[11:5];
    assign widx  = waddr_i[4:0];

    // A write in the same cycle overrides that cycle's increment; the
    // inhibit register seen here is the pre-write value.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            mcycle   <= '0;
            minstret <= '0;
            inhibit  <= '0;
        end else begin
            if (we_i && waddr_i == 12'hB00)
                mcycle <= wdata_i;
            else if (!inhibit[0])
                mcycle <= mcycle + 64'd1;

            if (we_i && waddr_i == 12'hB02)
                minstret <= wdata_i;
            else if (!inhibit[2])
                minstret <= minstret + 64'(instret_i);

            if (we_i && waddr_i == 12'h320)
                inhibit <= wdata_i[31:0] & INH_MASK;
        end
    end

`ifdef PRV664_HPM_EN
    logic [63:0]  hpm_cnt [HPM_NUM];
    logic [7:0]   hpm_sel [HPM_NUM];
    logic [255:0] evt_vec;

    // Shift so that bit k is event k; selector 0 and selectors above
    // HPM_EVT land on constant-zero bits and never count.
    assign evt_vec = 256'({hpm_event_i, 1'b0});

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            for (int i = 0; i < HPM_NUM; i++) begin
                hpm_cnt[i] <= '0;
                hpm_sel[i] <= '0;
            end
        end else begin
            for (int i = 0; i < HPM_NUM; i++) begin
                if (we_i && wpage == PAGE_MCNT && widx == 5'(i + 3))
                    hpm_cnt[i] <= wdata_i;
                else if (!inhibit[5'(i + 3)] && evt_vec[hpm_sel[i]])
                    hpm_cnt[i] <= hpm_cnt[i] + 64'd1;

                if (we_i && wpage == PAGE_MEVT && widx == 5'(i + 3))
                    hpm_sel[i] <= wdata_i[7:0];
            end
        end
    end
`else
    logic unused_hpm;
    assign unused_hpm = ^{hpm_event_i, HPM_NUM[0]};
`endif

    always_comb begin
        rdata_o = '0;
        hit_o   = 1'b0;
        if (raddr_i >= 12'hF11 && raddr_i <= 12'hF14) begin
            hit_o = 1'b1;
            case (raddr_i)
                12'hF11: rdata_o = MVENDORID;
                12'hF12: rdata_o = MARCHID;
                12'hF14: rdata_o = HARTID;
                default: rdata_o = '0;
            endcase
        end else if (rpage == PAGE_MCNT || rpage == PAGE_UCNT) begin
            if (ridx == 5'd0) begin
                hit_o   = 1'b1;
                rdata_o = mcycle;
            end else if (ridx == 5'd2) begin
                hit_o   = 1'b1;
                rdata_o = minstret;
            end else if (ridx >= 5'd3) begin
                hit_o = 1'b1;
`ifdef PRV664_HPM_EN
                for (int i = 0; i < HPM_NUM; i++)
                    if (ridx == 5'(i + 3)) rdata_o = hpm_cnt[i];
`endif
            end
        end else if (rpage == PAGE_MEVT) begin
            if (ridx == 5'd0) begin
                hit_o   = 1'b1;
                rdata_o = {32'h0, inhibit};
            end else if (ridx >= 5'd3) begin
                hit_o = 1'b1;
`ifdef PRV664_HPM_EN
                for (int i = 0; i < HPM_NUM; i++)
                    if (ridx == 5'(i + 3)) rdata_o = {56'h0, hpm_sel[i]};
`endif
            end
        end
    end

    // Identification constants and the user shadows (except the
    // unassigned time slot 0xC01) are read-only.
    assign wr_illegal_o = we_i &&
                          ((waddr_i >= 12'hF11 && waddr_i <= 12'hF14) ||
                           (wpage == PAGE_UCNT && widx != 5'd1));

endmodule

// File: tb/tb_csr_counter.sv
// Testbench for csr_counter: directed steps with a queue of expected
// read results, compared by immediate assertions.
module tb_csr_counter;

    localparam logic [63:0] HARTID = 64'hDEAD_BEEF_0000_0664;
`ifdef PRV664_HPM_EN
    localparam bit HPM = 1'b1;
`else
    localparam bit HPM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst;
    logic [11:0] raddr;
    logic [63:0] rdata;
    logic        hit;
    logic        we;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        illegal;
    logic [1:0]  instret;
    logic [7:0]  evt;

    int checks = 0;
    int errors = 0;

    logic [64:0] exp_q[$];
    string       tag_q[$];

    always #10 clk = ~clk;

    csr_counter #(.HARTID(HARTID), .HPM_NUM(4), .HPM_EVT(8)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .hit_o       (hit),
        .we_i        (we),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .wr_illegal_o(illegal),
        .instret_i   (instret),
        .hpm_event_i (evt)
    );

    function automatic logic [63:0] hv(input logic [63:0] v);
        return HPM ? v : 64'h0;
    endfunction

    task automatic chk(input string tag, input logic [11:0] a,
                       input logic exp_hit, input logic [63:0] exp_val);
        logic [64:0] e;
        string       t;
        raddr = a;
        exp_q.push_back({exp_hit, exp_val});
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert ({hit, rdata} === e) else begin
            errors++;
            $error("FAIL %s: observed hit=%b data=%h, expected hit=%b data=%h",
                   t, hit, rdata, e[64], e[63:0]);
        end
    endtask

    task automatic chk_ill(input string tag, input logic expv);
        checks++;
        assert (illegal === expv) else begin
            errors++;
            $error("FAIL %s: observed wr_illegal=%b, expected %b", tag, illegal, expv);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            evt = e;
            @(negedge clk);
            evt = 8'h0;
            @(negedge clk);
        end
    endtask

    initial begin
        arst = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        instret = 2'd0; evt = 8'h0;
        repeat (2) @(negedge clk);

        // Held in reset
        chk("rst_mcycle",  12'hB00, 1'b1, 64'h0);
        chk("rst_minstret", 12'hB02, 1'b1, 64'h0);
        chk("rst_mhartid", 12'hF14, 1'b1, HARTID);
        chk("rst_marchid", 12'hF12, 1'b1, 64'h0056_4F53_4B48_4F44);

        // Release, idle 10 cycles
        arst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_mcycle",   12'hB00, 1'b1, 64'd10);
        chk("idle_minstret", 12'hB02, 1'b1, 64'd0);
        chk("mhartid",       12'hF14, 1'b1, HARTID);
        chk("marchid",       12'hF12, 1'b1, 64'h0056_4F53_4B48_4F44);
        chk("mvendorid",     12'hF11, 1'b1, 64'h004B_4F52_4F4C_4556);
        chk("mimpid",        12'hF13, 1'b1, 64'h0);

        // mcycle wrap
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_fe", 12'hB00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        chk("wrap_ff", 12'hB00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap_0",  12'hB00, 1'b1, 64'h0);
        chk("cycle_shadow", 12'hC00, 1'b1, 64'h0);

        // minstret accumulation and write priority
        instret = 2'd2;
        repeat (3) @(negedge clk);
        instret = 2'd1;
        @(negedge clk);
        instret = 2'd0;
        chk("minstret_7", 12'hB02, 1'b1, 64'd7);
        chk("instret_shadow", 12'hC02, 1'b1, 64'd7);
        instret = 2'd2;
        wr(12'hB02, 64'd100);
        instret = 2'd0;
        chk("minstret_wr", 12'hB02, 1'b1, 64'd100);
        instret = 2'd2;
        @(negedge clk);
        instret = 2'd0;
        chk("minstret_102", 12'hB02, 1'b1, 64'd102);

        // mcountinhibit
        wr(12'h320, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("inhibit_mask", 12'h320, 1'b1, HPM ? 64'h7D : 64'h5);
        instret = 2'd2;
        @(negedge clk);
        instret = 2'd0;
        chk("minstret_inh", 12'hB02, 1'b1, 64'd102);
        wr(12'hB00, 64'd300);
        chk("mcycle_300", 12'hB00, 1'b1, 64'd300);
        @(negedge clk);
        chk("mcycle_inh", 12'hB00, 1'b1, 64'd300);
        wr(12'h320, 64'h0);
        chk("inh_old_used", 12'hB00, 1'b1, 64'd300);
        chk("inhibit_0",    12'h320, 1'b1, 64'h0);
        @(negedge clk);
        chk("mcycle_301", 12'hB00, 1'b1, 64'd301);

        // Performance counters
        wr(12'h323, 64'h5);
        chk("mhpmevent3", 12'h323, 1'b1, hv(64'h5));
        pulse(8'h10, 4);
        pulse(8'h08, 2);
        chk("hpm3_4",      12'hB03, 1'b1, hv(64'd4));
        chk("hpm3_shadow", 12'hC03, 1'b1, hv(64'd4));
        wr(12'h320, 64'h8);
        chk("inhibit_b3", 12'h320, 1'b1, hv(64'h8));
        pulse(8'h10, 3);
        chk("hpm3_inh", 12'hB03, 1'b1, hv(64'd4));
        wr(12'h320, 64'h0);
        wr(12'hB03, 64'd55);
        chk("hpm3_wr55", 12'hB03, 1'b1, hv(64'd55));
        wr(12'h324, 64'h9);
        chk("mhpmevent4_9", 12'h324, 1'b1, hv(64'h9));
        pulse(8'hFF, 2);
        chk("hpm4_oor", 12'hB04, 1'b1, 64'h0);
        wr(12'h324, 64'h1);
        pulse(8'h01, 2);
        chk("hpm4_evt1", 12'hB04, 1'b1, hv(64'd2));
        we = 1'b1; waddr = 12'hB10; wdata = 64'd77;
        #1;
        chk_ill("ill_b10", 1'b0);
        @(negedge clk);
        we = 1'b0;
        chk("hpm16_unimpl", 12'hB10, 1'b1, 64'h0);

        // Illegal writes to read-only CSRs
        we = 1'b1; waddr = 12'hB00; wdata = 64'd5000;
        #1;
        chk_ill("ill_b00", 1'b0);
        @(negedge clk);
        waddr = 12'hC00; wdata = 64'd123;
        #1;
        chk_ill("ill_c00", 1'b1);
        chk("mcycle_5000", 12'hB00, 1'b1, 64'd5000);
        waddr = 12'hF14;
        #1;
        chk_ill("ill_f14", 1'b1);
        waddr = 12'hC03;
        #1;
        chk_ill("ill_c03", 1'b1);
        waddr = 12'hC00;
        @(negedge clk);
        waddr = 12'hC01;
        #1;
        chk_ill("ill_c01", 1'b0);
        we = 1'b0;
        #1;
        chk_ill("ill_idle", 1'b0);
        chk("mcycle_5001", 12'hB00, 1'b1, 64'd5001);
        chk("miss_7c0", 12'h7C0, 1'b0, 64'h0);
        chk("miss_b01", 12'hB01, 1'b0, 64'h0);

        // Reset asserted between edges
        instret = 2'd2;
        repeat (2) @(negedge clk);
        #2;
        arst = 1'b0;
        #1;
        chk("arst_mcycle",   12'hB00, 1'b1, 64'h0);
        chk("arst_minstret", 12'hB02, 1'b1, 64'h0);
        chk("arst_hpm3",     12'hB03, 1'b1, 64'h0);
        chk("arst_evt3",     12'h323, 1'b1, 64'h0);
        chk("arst_hartid",   12'hF14, 1'b1, HARTID);
        @(negedge clk);
        arst = 1'b1;
        instret = 2'd0;
        @(negedge clk);
        chk("post_rst_mcycle", 12'hB00, 1'b1, 64'd1);
        chk("post_rst_minstret", 12'hB02, 1'b1, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
